// File: rtl/uart_tx_fifo_if.sv
// Host-side and UART-side handshake bundle for uart_tx_fifo.
// The slave modport is the buffer itself; master is whoever drives it.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  tx_en;
    logic                  flush;
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data_in;
    logic                  tx_active;
    logic                  done_tx;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  overflow;

    modport slave (
        input  wr_valid, wr_data, tx_en, flush, tx_active, done_tx,
        output wr_ready, start, tx_data_in, fifo_count, fifo_empty, fifo_full, overflow
    );

    modport master (
        output wr_valid, wr_data, tx_en, flush, tx_active, done_tx,
        input  wr_ready, start, tx_data_in, fifo_count, fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus frame sequencer feeding a UART transmitter.
// Bytes queue from the host; one is popped per frame and held on
// tx_data_in while the UART runs, with an optional idle gap between frames.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 0
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [7:0]  GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  start_q;
    logic                  empty_q;
    logic                  full_q;
    logic                  overflow_q;
    logic [7:0]            gap_cnt;
    logic                  push;
    logic                  pop;

    // Push/pop qualification; flush wins over both so the queue ends empty.
    always_comb begin
        push = bus.wr_valid && !full_q && !bus.flush;
        pop  = (state == IDLE) && bus.tx_en && !empty_q && !bus.flush;
    end

    // Next frame-sequencer state from the UART handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (pop) state_next = LOAD;
            LOAD:      state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.done_tx)        state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
                else if (bus.tx_active) state_next = WAIT_DONE;
            end
            WAIT_DONE: if (bus.done_tx) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:       if (gap_cnt == '0) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Occupancy after this edge; drives both the counter and the flags.
    always_comb begin
        count_next = count;
        if (bus.flush)         count_next = '0;
        else if (push && !pop) count_next = count + CNT_W'(1);
        else if (pop && !push) count_next = count - CNT_W'(1);
    end

    // Sequencer state, start pulse register and inter-frame gap counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            start_q <= (state_next == LOAD);
            if (state_next == GAP && state != GAP) gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // Pointers, registered status flags, sticky overflow and output byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            data_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (bus.flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                data_q <= mem[rd_ptr];
            end
            count   <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == CNT_W'(DEPTH));
            if (bus.wr_valid && full_q) overflow_q <= 1'b1;
        end
    end

    assign bus.wr_ready   = !full_q;
    assign bus.start      = start_q;
    assign bus.tx_data_in = data_q;
    assign bus.fifo_count = count;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.overflow   = overflow_q;
endmodule
